cmp_stream_tracker: RTL

//  Sequential front/back stage wrapped around the combinational 8-bit comparator (ports aa, bb -> EE, GG).
//  - Accepts a stream of unsigned samples over a valid/ready handshake.
//  - Drives each sample (aa) and the running maximum (bb) onto the comparator.
//  - Waits a programmable settle time for gate delays, samples EE/GG, updates max and statistics.

---
 rtl/cmp_tracker_pkg.sv | 22 ++
 rtl/cmp_settle_timer.sv | 28 ++
 rtl/cmp_stream_tracker.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cmp_tracker_pkg.sv
// Shared types and defaults for the comparator stream tracker.
// Latency: n/a. Backpressure: n/a.
package cmp_tracker_pkg;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRIVE_MAX = 2'd1,
        DRIVE_MIN = 2'd2
    } state_t;

    // Saturating increment for counters up to 32 bits wide; callers truncate to cnt_w.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int cnt_w);
        logic [31:0] all_ones;
        all_ones = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
        return (v >= all_ones) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cmp_settle_timer.sv
// Load/decrement settle counter; o_done is high while the count is zero.
// Latency: done asserts load_val cycles after a load. Backpressure: none.
// Usage: load SETTLE_CYCLES-1 when the comparator inputs change.
module cmp_settle_timer #(
    parameter int CW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_done
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/cmp_stream_tracker.sv
// Running max (and optional min, macro CMP_MIN_TRACK_EN) tracker around an external comparator.
// Latency: SETTLE_CYCLES per compared sample (2*SETTLE_CYCLES with min tracking); first sample 1 cycle.
// Backpressure: in_ready low while a compare is in flight or clr is asserted.
module cmp_stream_tracker
    import cmp_tracker_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic [WIDTH-1:0] max_val,
    output logic             max_valid,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic             busy
`ifdef CMP_MIN_TRACK_EN
    ,
    output logic [WIDTH-1:0] min_val
`endif
);

    localparam int          TW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_live;
    logic             w_ready;
    logic             w_hs;
    logic             w_load;
    logic             w_done;
    logic             w_eq;
    logic             w_gt;
    logic [WIDTH-1:0] r_cmp_a;
    logic [WIDTH-1:0] r_cmp_b;
    logic [WIDTH-1:0] r_max;
    logic             r_max_valid;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_eq_cnt;
`ifdef CMP_MIN_TRACK_EN
    logic [WIDTH-1:0] r_min;
`endif

    // Undriven or unknown comparator outputs must never count as a hit.
    assign w_eq = (cmp_eq === 1'b1);
    assign w_gt = (cmp_gt === 1'b1);

    cmp_settle_timer #(
        .CW(TW)
    ) u_timer (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_load_val (SETTLE_LOAD),
        .o_done     (w_done)
    );

    // Holds in_ready low for the whole reset period and its release cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_hs        = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = r_live && !clr;
                w_hs    = in_valid && w_ready;
                if (w_hs && r_max_valid) begin
                    w_state_nxt = DRIVE_MAX;
                    w_load      = 1'b1;
                end
            end
            DRIVE_MAX: begin
                if (w_done) begin
`ifdef CMP_MIN_TRACK_EN
                    w_state_nxt = DRIVE_MIN;
                    w_load      = 1'b1;
`else
                    w_state_nxt = IDLE;
`endif
                end
            end
            DRIVE_MIN: begin
`ifdef CMP_MIN_TRACK_EN
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
        if (clr) begin
            w_state_nxt = IDLE;
            w_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp_a      <= '0;
            r_cmp_b      <= '0;
            r_max        <= '0;
            r_max_valid  <= 1'b0;
            r_sample_cnt <= '0;
            r_eq_cnt     <= '0;
`ifdef CMP_MIN_TRACK_EN
            r_min        <= '0;
`endif
        end else if (clr) begin
            r_cmp_a      <= '0;
            r_cmp_b      <= '0;
            r_max        <= '0;
            r_max_valid  <= 1'b0;
            r_sample_cnt <= '0;
            r_eq_cnt     <= '0;
`ifdef CMP_MIN_TRACK_EN
            r_min        <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs && !r_max_valid) begin
                        r_max        <= in_data;
                        r_max_valid  <= 1'b1;
                        r_sample_cnt <= CNT_W'(sat_inc(32'(r_sample_cnt), CNT_W));
`ifdef CMP_MIN_TRACK_EN
                        r_min        <= in_data;
`endif
                    end else if (w_hs) begin
                        r_cmp_a <= in_data;
                        r_cmp_b <= r_max;
                    end
                end
                DRIVE_MAX: begin
                    if (w_done) begin
                        // Both flags high is a broken comparator: count the sample, trust nothing else.
                        if (w_gt && !w_eq) begin
                            r_max <= r_cmp_a;
                        end
                        if (w_eq && !w_gt) begin
                            r_eq_cnt <= CNT_W'(sat_inc(32'(r_eq_cnt), CNT_W));
                        end
                        r_sample_cnt <= CNT_W'(sat_inc(32'(r_sample_cnt), CNT_W));
`ifdef CMP_MIN_TRACK_EN
                        r_cmp_b <= r_min;
`endif
                    end
                end
`ifdef CMP_MIN_TRACK_EN
                DRIVE_MIN: begin
                    if (w_done && !w_gt && !w_eq) begin
                        r_min <= r_cmp_a;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready   = w_ready;
    assign cmp_a      = r_cmp_a;
    assign cmp_b      = r_cmp_b;
    assign max_val    = r_max;
    assign max_valid  = r_max_valid;
    assign sample_cnt = r_sample_cnt;
    assign eq_cnt     = r_eq_cnt;
    assign busy       = (r_state != IDLE);
`ifdef CMP_MIN_TRACK_EN
    assign min_val    = r_min;
`endif

endmodule
